axis_rr_packet_arbiter: RTL
===========================

AXIS_RR_PACKET_ARBITER -- requirements
Module: axis_rr_packet_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 40, width of tdata on every port (mesh AXIS channel width).
REQ-002 Parameter ID_WIDTH, default 3, width of tid on every port.
REQ-003 Parameter N_IN, default 5, number of competing input ports (home + 4 directions).
REQ-004 ACLK  input  1  single clock; all state updates on rising edge.
REQ-005 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 s_tvalid  input  N_IN  per-input beat valid.
REQ-007 s_tready  output  N_IN  per-input beat ready.
REQ-008 s_tdata  input  N_IN*DATA_WIDTH  per-input data, input k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 s_tid  input  N_IN*ID_WIDTH  per-input id, same packing as s_tdata.
REQ-010 s_tlast  input  N_IN  per-input last-beat-of-packet flag.
REQ-011 m_tvalid / m_tready / m_tdata / m_tid / m_tlast  output/input/output/output/output  1/1/DATA_WIDTH/ID_WIDTH/1  single output AXIS port toward router link.
REQ-012 grant  output  N_IN  one-hot current owner, all-zero when unlocked.

Function
REQ-013 Two-state FSM: IDLE, LOCKED.
REQ-014 IDLE: if any s_tvalid is high, select first valid input searching from rr_ptr upward with wrap modulo N_IN; register it in grant and move to LOCKED on next edge; no beat accepted in IDLE.
REQ-015 IDLE with no s_tvalid: remain IDLE, grant all-zero.
REQ-016 LOCKED: s_tready[g] = (!m_tvalid || m_tready) for granted input g; s_tready of all other inputs = 0.
REQ-017 Output is one register stage: accepted beat (tdata, tid, tlast) is loaded into m_* and m_tvalid set on the following edge; latency input-accept to m_tvalid = 1 cycle.
REQ-018 m_tvalid clears on an edge where m_tready=1 and no new beat is loaded; simultaneous drain and load keeps m_tvalid=1 with new data (full throughput, 1 beat/cycle within a packet).
REQ-019 m_* outputs shall hold stable while m_tvalid=1 and m_tready=0.
REQ-020 Accepted beat with s_tlast=1 in LOCKED: next state IDLE, grant cleared, rr_ptr <= (g+1) mod N_IN.
REQ-021 Grant is never changed mid-packet regardless of other inputs' s_tvalid; packets from different inputs never interleave on m_*.
REQ-022 s_tvalid of granted input dropping mid-packet: stay LOCKED, wait; no timeout.
REQ-023 Single-beat packet (tlast on first beat): one accept, then IDLE; each packet costs exactly one IDLE arbitration cycle.

Reset
REQ-024 ARESETn low: state IDLE, rr_ptr 0, grant 0, m_tvalid 0, m_tdata 0, m_tid 0, m_tlast 0, s_tready 0, counters 0, immediately and asynchronously.
REQ-025 Reset mid-packet discards the in-flight packet and output register contents; after release arbitration restarts from input 0.

Configuration
REQ-026 Macro AXIS_ARB_PERF_EN defined: adds output pkt_cnt (N_IN*16 bits), per-input 16-bit counters incremented on each accepted tlast beat of that input, saturating at 0xFFFF.
REQ-027 Macro AXIS_ARB_PERF_EN undefined: no pkt_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-028 Single input 2 with 3-beat packet, m_tready=1 -> grant=5'b00100 one cycle after s_tvalid, m_tdata beats in order, m_tlast on 3rd, then grant=0, rr_ptr=3.
REQ-029 Inputs 0 and 3 each presenting continuous 2-beat packets, m_tready=1 -> output order 0,3,0,3; no interleaving inside packets.
REQ-030 Granted 4-beat packet, m_tready held low cycles 2-4 -> m_tdata/m_tlast stable during stall, s_tready[g]=0, no beat lost or duplicated.
REQ-031 ARESETn pulsed low after beat 2 of 4 -> m_tvalid=0, grant=0 same cycle; after release new request from input 1 wins immediately.
REQ-032 With AXIS_ARB_PERF_EN, 70000 single-beat packets on input 4 -> pkt_cnt[4] = 0xFFFF, other counters 0.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter
// Round-robin, packet-locked arbiter merging N_IN AXI-Stream inputs onto one
// registered output. A grant is held from the first beat of a packet to its
// tlast beat. The next search starts one input past the last owner.
// Optional build macro AXIS_ARB_PERF_EN adds the pkt_cnt port, which holds
// per-input saturating counters of completed packets.
module axis_rr_packet_arbiter #(
  parameter int DATA_WIDTH = 40,
  parameter int ID_WIDTH   = 3,
  parameter int N_IN       = 5
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [N_IN-1:0]            s_tvalid,
  output logic [N_IN-1:0]            s_tready,
  input  logic [N_IN*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_IN*ID_WIDTH-1:0]   s_tid,
  input  logic [N_IN-1:0]            s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic [ID_WIDTH-1:0]        m_tid,
  output logic                       m_tlast,
  output logic [N_IN-1:0]            grant
`ifdef AXIS_ARB_PERF_EN
  ,
  output logic [N_IN*16-1:0]         pkt_cnt
`endif
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [N_IN-1:0] ONE_HOT0 = N_IN'(1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      g_idx;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;
  logic                  pick_found;
  logic                  out_ready;
  logic                  accept;
  logic                  accept_last;
  logic [DATA_WIDTH-1:0] in_data [N_IN];
  logic [ID_WIDTH-1:0]   in_id   [N_IN];

  // Split the flat input buses into per-input lanes.
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      in_data[k] = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      in_id[k]   = s_tid[k*ID_WIDTH +: ID_WIDTH];
    end
  end

  // Find the first valid input, starting at rr_ptr and wrapping modulo N_IN.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_IN; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % N_IN);
      if (!pick_found && s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // The owner may move a beat whenever the output register is empty or is
  // draining in this cycle. Only the granted lane ever sees ready.
  always_comb begin
    out_ready   = !m_tvalid || m_tready;
    s_tready    = (state == LOCKED && out_ready) ? grant : '0;
    accept      = (state == LOCKED) && out_ready && s_tvalid[g_idx];
    accept_last = accept && s_tlast[g_idx];
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values no matter how the blocks are ordered.
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: one arbitration cycle, then locked until tlast is accepted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_found)  state_nxt = LOCKED;
      LOCKED:  if (accept_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant owner and round-robin pointer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant  <= '0;
      g_idx  <= '0;
      rr_ptr <= '0;
    end else if (state == IDLE && pick_found) begin
      grant <= ONE_HOT0 << pick_idx;
      g_idx <= pick_idx;
    end else if (accept_last) begin
      grant  <= '0;
      rr_ptr <= (g_idx == IDX_W'(N_IN - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  // Output register stage: a new beat can load while the old one drains.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: the datapath registers are reset as well as m_tvalid, so a reset
    // mid-packet leaves no stale beat visible on m_tdata, m_tid or m_tlast.
    if (!ARESETn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tid    <= '0;
      m_tlast  <= 1'b0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= in_data[g_idx];
      m_tid    <= in_id[g_idx];
      m_tlast  <= s_tlast[g_idx];
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_ARB_PERF_EN
  logic [15:0] cnt [N_IN];

  // Count completed packets per input, saturating at all-ones.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int k = 0; k < N_IN; k++) cnt[k] <= '0;
    end else if (accept_last && cnt[g_idx] != 16'hFFFF) begin
      cnt[g_idx] <= cnt[g_idx] + 16'd1;
    end
  end

  // Pack the counters, input k at bits [k*16 +: 16].
  always_comb begin
    for (int k = 0; k < N_IN; k++) pkt_cnt[k*16 +: 16] = cnt[k];
  end
`endif

endmodule
